// File: rtl/vector_mem_sequencer.sv
// Serialises one vector load/store into per-lane memory accesses and stalls EX/MEM until done.
// Optional per-lane skip mask enabled by defining VMEM_LANE_MASK_EN.
//
// state  | meaning
// IDLE   | waiting for start; nothing captured in flight
// ACCESS | one lane request presented per cycle until mem_ready on the last lane
// DONE   | one-cycle completion pulse; load_data valid for writeback
module vector_mem_sequencer #(
    parameter int WIDTH        = 24,
    parameter int VECTOR_WIDTH = 8,
    localparam int LW          = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                is_store,
    input  logic [WIDTH-1:0]                    base_addr,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  store_data,
    input  logic                                flush,
    input  logic                                mem_ready,
    input  logic [WIDTH-1:0]                    mem_rdata,
`ifdef VMEM_LANE_MASK_EN
    input  logic [VECTOR_WIDTH-1:0]             lane_mask,
`endif
    output logic [WIDTH-1:0]                    mem_addr,
    output logic [WIDTH-1:0]                    mem_wdata,
    output logic                                mem_we,
    output logic                                mem_re,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  load_data,
    output logic                                stall,
    output logic                                done,
    output logic [LW-1:0]                       lane_idx
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic                                is_store_q;
    logic [WIDTH-1:0]                    base_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  wdata_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  load_q;
    logic [LW-1:0]                       lane_q, lane_d;
    logic                                capture;
    logic                                ld_we;
    logic                                in_access;

    logic [LW-1:0]                       first_lane;
    logic [LW-1:0]                       next_lane;
    logic                                any_lane;
    logic                                has_next;

`ifdef VMEM_LANE_MASK_EN
    logic [VECTOR_WIDTH-1:0]             mask_q;

    // Descending scans so the lowest qualifying lane is the one left standing.
    always_comb begin
        first_lane = '0;
        any_lane   = 1'b0;
        next_lane  = lane_q;
        has_next   = 1'b0;
        for (int i = VECTOR_WIDTH - 1; i >= 0; i--) begin
            if (lane_mask[i]) begin
                any_lane   = 1'b1;
                first_lane = LW'(i);
            end
            if (mask_q[i] && (i > int'(lane_q))) begin
                has_next  = 1'b1;
                next_lane = LW'(i);
            end
        end
    end
`else
    always_comb begin
        first_lane = '0;
        any_lane   = 1'b1;
        next_lane  = lane_q + 1'b1;
        has_next   = (lane_q != LW'(VECTOR_WIDTH - 1));
    end
`endif

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        capture = 1'b0;
        ld_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    capture = 1'b1;
                    lane_d  = first_lane;
                    state_d = any_lane ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                // Flush wins over a same-cycle ack; that lane's read data is dropped.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    ld_we = !is_store_q;
                    if (has_next) begin
                        lane_d = next_lane;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
            lane_q     <= '0;
`ifdef VMEM_LANE_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (capture) begin
                is_store_q <= is_store;
                base_q     <= base_addr;
                wdata_q    <= store_data;
`ifdef VMEM_LANE_MASK_EN
                mask_q     <= lane_mask;
`endif
            end
            if (ld_we) begin
                load_q[lane_q] <= mem_rdata;
            end
        end
    end

    assign in_access = (state_q == S_ACCESS);

    // Address arithmetic is modulo 2^WIDTH; carry out of the top bit is dropped.
    assign mem_addr  = in_access ? (base_q + WIDTH'(lane_q)) : '0;
    assign mem_wdata = (in_access && is_store_q) ? wdata_q[lane_q] : '0;
    assign mem_we    = in_access && is_store_q;
    assign mem_re    = in_access && !is_store_q;
    assign stall     = ((state_q == S_IDLE) && start && !flush) || in_access;
    assign done      = (state_q == S_DONE);
    assign lane_idx  = lane_q;
    assign load_data = load_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: table of vector ops plus flush/reset sequences.
// Request scoreboard is filled on start and drained on accepted memory requests.
module tb_vector_mem_sequencer;

    localparam int W  = 24;
    localparam int VW = 8;
    localparam int LW = 3;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   is_store;
    logic [W-1:0]           base_addr;
    logic [VW-1:0][W-1:0]   store_data;
    logic                   flush;
    logic                   mem_ready;
    logic [W-1:0]           mem_rdata;
    logic [W-1:0]           mem_addr;
    logic [W-1:0]           mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic [VW-1:0][W-1:0]   load_data;
    logic                   stall;
    logic                   done;
    logic [LW-1:0]          lane_idx;
`ifdef VMEM_LANE_MASK_EN
    logic [VW-1:0]          lane_mask;
`endif

    vector_mem_sequencer #(.WIDTH(W), .VECTOR_WIDTH(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_data (store_data),
        .flush      (flush),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
`ifdef VMEM_LANE_MASK_EN
        .lane_mask  (lane_mask),
`endif
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .lane_idx   (lane_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: every word reads back as 0xA00 + its address.
    assign mem_rdata = mem_re ? (mem_addr + W'('hA00)) : '0;

    typedef struct {
        logic         is_store;
        logic [W-1:0] base;
        logic         alt;
        int           exp_done;
    } op_t;

    typedef struct {
        logic [LW-1:0] lane;
        logic [W-1:0]  addr;
        logic [W-1:0]  wdata;
        logic          we;
    } req_t;

    op_t                  tbl[6];
    req_t                 q[$];
    logic [VW-1:0][W-1:0] exp_ld;
    int                   checks;
    int                   fails;

    task automatic chk(input string name, input logic [W*VW-1:0] act, input logic [W*VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic lane_en(input int i);
`ifdef VMEM_LANE_MASK_EN
        return lane_mask[i];
`else
        return (i >= 0);
`endif
    endfunction

    task automatic drive_start(input int t);
        req_t r;
        start     = 1'b1;
        is_store  = tbl[t].is_store;
        base_addr = tbl[t].base;
        for (int i = 0; i < VW; i++)
            store_data[i] = W'((i + 1) * 'h11 + t * 'h1000);
        for (int i = 0; i < VW; i++) begin
            if (lane_en(i)) begin
                r.lane  = LW'(i);
                r.addr  = tbl[t].base + W'(i);
                r.wdata = tbl[t].is_store ? store_data[i] : '0;
                r.we    = tbl[t].is_store;
                q.push_back(r);
            end
        end
    endtask

    // Called at the negedge: compare any active request with the scoreboard head.
    task automatic mon();
        req_t e;
        if (mem_we || mem_re) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
            end else begin
                e = q[0];
                chk("req_lane", lane_idx, e.lane);
                chk("req_addr", mem_addr, e.addr);
                chk("req_wdata", mem_wdata, e.wdata);
                chk("req_we", mem_we, e.we);
                chk("req_re", mem_re, !e.we);
                if (mem_ready && !flush) begin
                    e = q.pop_front();
                    if (!e.we) exp_ld[e.lane] = e.addr + W'('hA00);
                end
            end
        end
    endtask

    task automatic run_op(input int t, input int exp_done);
        int k;
        bit got;
        drive_start(t);
        @(negedge clk);
        chk("start_stall", stall, 1);
        chk("start_strobes", {mem_we, mem_re}, 0);
        chk("start_done", done, 0);
        chk("ld_before", load_data, exp_ld);
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 0;
        k     = 1;
        while (!got && k <= 40) begin
            mem_ready = tbl[t].alt ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            mon();
            if (done) begin
                got = 1;
                chk("done_cycle", k, exp_done);
                chk("done_stall", stall, 0);
                chk("ld_after", load_data, exp_ld);
                chk("reqs_left", q.size(), 0);
            end else begin
                chk("busy_stall", stall, 1);
            end
            @(posedge clk);
            #1;
            k++;
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", exp_done);
        end
        q.delete();
        mem_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 24'h000100, 1'b0, 9};
        tbl[1] = '{1'b0, 24'h000200, 1'b1, 17};
        tbl[2] = '{1'b1, 24'hFFFFFE, 1'b0, 9};
        tbl[3] = '{1'b0, 24'hFFFFFC, 1'b0, 9};
        tbl[4] = '{1'b1, 24'h000000, 1'b1, 17};
        tbl[5] = '{1'b0, 24'h000300, 1'b0, 9};

        checks     = 0;
        fails      = 0;
        exp_ld     = '0;
        rst        = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        base_addr  = '0;
        store_data = '0;
        flush      = 1'b0;
        mem_ready  = 1'b0;
`ifdef VMEM_LANE_MASK_EN
        lane_mask  = '1;
`endif

        #2 rst = 1'b0;
        #2;
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_strobes", {mem_we, mem_re}, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_lane", lane_idx, 0);
        chk("rst_ld", load_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 5; t++)
            run_op(t, tbl[t].exp_done);

        // start with a same-cycle flush must not launch an op
        start    = 1'b1;
        is_store = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("sf_stall", stall, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("sf_idle", {mem_we, mem_re, stall}, 0);
        @(posedge clk);
        #1;

        // flush while lane 3 of a load is acknowledged
        drive_start(5);
        @(posedge clk);
        #1;
        start     = 1'b0;
        mem_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            mon();
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_lane", lane_idx, 3);
        chk("flush_done", done, 0);
        mon();
        @(posedge clk);
        #1;
        flush     = 1'b0;
        mem_ready = 1'b0;
        q.delete();
        run_op(3, 9);

        // asynchronous reset in the middle of a store
        drive_start(0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        mem_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mon();
            @(posedge clk);
            #1;
        end
        chk("pre_rst_lane", lane_idx, 4);
        #2 rst = 1'b0;
        #1;
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_strobes", {mem_we, mem_re}, 0);
        chk("arst_stall", stall, 0);
        chk("arst_lane", lane_idx, 0);
        chk("arst_ld", load_data, 0);
        exp_ld    = '0;
        mem_ready = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 9);

`ifdef VMEM_LANE_MASK_EN
        lane_mask = 8'b1000_0101;
        run_op(0, 4);
        lane_mask = 8'b0110_0000;
        run_op(3, 3);
        lane_mask = 8'b0000_0000;
        run_op(1, 1);
        lane_mask = '1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
